// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, MEM-stage
// flag bit positions, FSM state encoding and the priority encoder.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_CODE_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_CODE_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_CODE_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_CODE_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_CODE_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_CODE_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_CODE_ERET     = 32'h0000_000e;

    localparam int EXC_BIT_SYSCALL  = 0;
    localparam int EXC_BIT_INVALID  = 1;
    localparam int EXC_BIT_TRAP     = 2;
    localparam int EXC_BIT_OVERFLOW = 3;
    localparam int EXC_BIT_ERET     = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_t;

    // Fixed-priority selection; EXC_CODE_NONE means nothing to take.
    function automatic logic [31:0] select_code(input logic int_pending,
                                                input logic [4:0] exc);
        logic [31:0] code;
        code = EXC_CODE_NONE;
        if (int_pending)                 code = EXC_CODE_INT;
        else if (exc[EXC_BIT_SYSCALL])   code = EXC_CODE_SYSCALL;
        else if (exc[EXC_BIT_INVALID])   code = EXC_CODE_INVALID;
        else if (exc[EXC_BIT_TRAP])      code = EXC_CODE_TRAP;
        else if (exc[EXC_BIT_OVERFLOW])  code = EXC_CODE_OVERFLOW;
        else if (exc[EXC_BIT_ERET])      code = EXC_CODE_ERET;
        return code;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-bit, multi-stage flop synchronizer for the external interrupt lines.
// Each bit is synchronized independently; lines are level-sensitive.
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_reg[gi] <= '0;
                end else if (gi == 0) begin
                    stage_reg[gi] <= async_in;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign sync_out = stage_reg[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: samples MEM-stage events in IDLE, reports the
// winning code to CP0, flushes the pipeline and then redirects the PC once.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_raw_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [4:0]  mem_exc_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        pc_valid_o,
    output logic        busy_o
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    exc_state_t  state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [31:0] code_reg;
    logic [31:0] addr_reg;
    logic        ds_reg;
    logic [31:0] target_reg;
    logic [31:0] new_pc_reg;

    logic [5:0]  sync_int;
    logic        int_pending;
    logic [31:0] sel_code;
    logic        event_take;

    int_sync #(
        .WIDTH  (6),
        .STAGES (2)
    ) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (int_raw_i),
        .sync_out (sync_int)
    );

    // The timer interrupt shares hardware line 5 with the external source.
    assign int_o = {sync_int[5] | timer_int_i, sync_int[4:0]};

    assign int_pending = ((cause_i[15:8] & status_i[15:8]) != 8'h00)
                         && status_i[0] && !status_i[1] && mem_valid_i;
    assign sel_code    = select_code(int_pending, mem_exc_i);
    assign event_take  = (state_reg == ST_IDLE) && mem_valid_i
                         && (sel_code != EXC_CODE_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        flush_o      = 1'b0;
        pc_valid_o   = 1'b0;
        excepttype_o = EXC_CODE_NONE;
        case (state_reg)
            ST_IDLE: begin
                if (event_take) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
                if (cnt_reg == 4'd0) excepttype_o = code_reg;
                if (cnt_reg == FLUSH_LAST) state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_valid_o = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= 4'd0;
            code_reg   <= EXC_CODE_NONE;
            addr_reg   <= 32'h0;
            ds_reg     <= 1'b0;
            target_reg <= 32'h0;
            new_pc_reg <= 32'h0;
        end else begin
            if (event_take) begin
                cnt_reg    <= 4'd0;
                code_reg   <= sel_code;
                addr_reg   <= mem_pc_i;
                ds_reg     <= mem_in_delayslot_i;
                target_reg <= (sel_code == EXC_CODE_ERET) ? epc_i : EXC_VECTOR;
            end else if (state_reg == ST_FLUSH) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else begin
                cnt_reg <= 4'd0;
            end
            // Loaded one edge early so the target is stable for the whole
            // REDIRECT cycle and is then held afterwards.
            if (state_reg == ST_FLUSH && state_next == ST_REDIRECT) begin
                new_pc_reg <= target_reg;
            end
        end
    end

    assign current_inst_addr_o = addr_reg;
    assign is_in_delayslot_o   = ds_reg;
    assign new_pc_o            = new_pc_reg;
    assign busy_o              = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; inputs driven and outputs sampled
// on the falling clock edge.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  int_raw_i;
    logic        timer_int_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic [4:0]  mem_exc_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [5:0]  int_o;
    logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, pc_valid_o, busy_o;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_raw_i           (int_raw_i),
        .timer_int_i         (timer_int_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .mem_exc_i           (mem_exc_i),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .int_o               (int_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .pc_valid_o          (pc_valid_o),
        .busy_o              (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        int_raw_i          = 6'h0;
        timer_int_i        = 1'b0;
        status_i           = 32'h0;
        cause_i            = 32'h0;
        epc_i              = 32'h0;
        mem_exc_i          = 5'b0;
        mem_valid_i        = 1'b0;
        mem_pc_i           = 32'h0;
        mem_in_delayslot_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        timer_int_i = 1'b1;
        int_raw_i   = 6'h3f;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (int_o !== 6'h20) begin
            errors++; $display("FAIL reset_int_o got %h want %h", int_o, 6'h20);
        end
        checks++;
        if ({excepttype_o, current_inst_addr_o, new_pc_o} !== 96'h0) begin
            errors++; $display("FAIL reset_words got %h/%h/%h want 0", excepttype_o, current_inst_addr_o, new_pc_o);
        end
        checks++;
        if ({is_in_delayslot_o, flush_o, pc_valid_o, busy_o} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {is_in_delayslot_o, flush_o, pc_valid_o, busy_o});
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_syscall();
        mem_valid_i = 1'b1; mem_exc_i = 5'b00001; mem_pc_i = 32'h100;
        @(negedge clk);
        mem_valid_i = 1'b0; mem_exc_i = 5'b0; mem_pc_i = 32'h0;
        checks++;
        if (excepttype_o !== 32'h8 || current_inst_addr_o !== 32'h100) begin
            errors++; $display("FAIL syscall_code got %h@%h want 8@100", excepttype_o, current_inst_addr_o);
        end
        checks++;
        if (flush_o !== 1'b1 || busy_o !== 1'b1 || pc_valid_o !== 1'b0) begin
            errors++; $display("FAIL syscall_flush1 got f%b b%b v%b want 1 1 0", flush_o, busy_o, pc_valid_o);
        end
        @(negedge clk);
        checks++;
        if (flush_o !== 1'b1 || excepttype_o !== 32'h0) begin
            errors++; $display("FAIL syscall_flush2 got f%b code %h want 1 0", flush_o, excepttype_o);
        end
        @(negedge clk);
        checks++;
        if (pc_valid_o !== 1'b1 || new_pc_o !== 32'h20 || flush_o !== 1'b0) begin
            errors++; $display("FAIL syscall_redirect got v%b pc %h f%b want 1 20 0", pc_valid_o, new_pc_o, flush_o);
        end
        @(negedge clk);
        checks++;
        if (pc_valid_o !== 1'b0 || busy_o !== 1'b0 || new_pc_o !== 32'h20 || current_inst_addr_o !== 32'h100) begin
            errors++; $display("FAIL syscall_hold got v%b b%b pc %h addr %h want 0 0 20 100", pc_valid_o, busy_o, new_pc_o, current_inst_addr_o);
        end
        $display("txn syscall pc=100 -> new_pc=%h", new_pc_o);
    endtask

    task automatic test_interrupt();
        int_raw_i = 6'h04;
        @(negedge clk);
        checks++;
        if (int_o !== 6'h00) begin
            errors++; $display("FAIL int_sync1 got %h want 00", int_o);
        end
        @(negedge clk);
        checks++;
        if (int_o !== 6'h04) begin
            errors++; $display("FAIL int_sync2 got %h want 04", int_o);
        end
        int_raw_i = 6'h0;
        status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
        mem_valid_i = 1'b1; mem_pc_i = 32'h200; mem_in_delayslot_i = 1'b1;
        mem_exc_i = 5'b00100;
        @(negedge clk);
        status_i = 32'h0; cause_i = 32'h0; mem_valid_i = 1'b0;
        mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0; mem_exc_i = 5'b0;
        checks++;
        if (excepttype_o !== 32'h1 || current_inst_addr_o !== 32'h200 || is_in_delayslot_o !== 1'b1) begin
            errors++; $display("FAIL int_event got %h@%h ds%b want 1@200 ds1", excepttype_o, current_inst_addr_o, is_in_delayslot_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || is_in_delayslot_o !== 1'b1) begin
            errors++; $display("FAIL int_done got b%b ds%b want 0 1", busy_o, is_in_delayslot_o);
        end
        $display("txn interrupt pc=200 ds=1");
    endtask

    task automatic test_eret();
        mem_valid_i = 1'b1; mem_exc_i = 5'b10000; epc_i = 32'h0000_0abc; mem_pc_i = 32'h300;
        @(negedge clk);
        mem_valid_i = 1'b0; mem_exc_i = 5'b0; epc_i = 32'h0;
        checks++;
        if (excepttype_o !== 32'he) begin
            errors++; $display("FAIL eret_code got %h want e", excepttype_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pc_valid_o !== 1'b1 || new_pc_o !== 32'h0000_0abc) begin
            errors++; $display("FAIL eret_redirect got v%b pc %h want 1 abc", pc_valid_o, new_pc_o);
        end
        @(negedge clk);
        $display("txn eret -> new_pc=%h", new_pc_o);
    endtask

    task automatic test_priority();
        int seen = 0;
        mem_valid_i = 1'b1; mem_exc_i = 5'b01001; mem_pc_i = 32'h400;
        @(negedge clk);
        checks++;
        if (excepttype_o !== 32'h8) begin
            errors++; $display("FAIL prio_code got %h want 8", excepttype_o);
        end
        mem_exc_i = 5'b00100;
        @(negedge clk);
        if (excepttype_o !== 32'h0) seen++;
        @(negedge clk);
        if (excepttype_o !== 32'h0 || pc_valid_o !== 1'b1) seen++;
        mem_valid_i = 1'b0; mem_exc_i = 5'b0;
        @(negedge clk);
        if (excepttype_o !== 32'h0 || busy_o !== 1'b0) seen++;
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL prio_ignored got %0d bad cycles want 0", seen);
        end
        checks++;
        if (current_inst_addr_o !== 32'h400 || new_pc_o !== 32'h20) begin
            errors++; $display("FAIL prio_capture got %h/%h want 400/20", current_inst_addr_o, new_pc_o);
        end
        $display("txn priority overflow+syscall -> 8");
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        mem_valid_i = 1'b1; mem_exc_i = 5'b00010; mem_pc_i = 32'h500; mem_in_delayslot_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if ({excepttype_o, current_inst_addr_o, new_pc_o} !== 96'h0 ||
            {is_in_delayslot_o, flush_o, pc_valid_o, busy_o} !== 4'b0) begin
            errors++; $display("FAIL abort_outputs got %h/%h/%h %b want all 0", excepttype_o, current_inst_addr_o, new_pc_o, {is_in_delayslot_o, flush_o, pc_valid_o, busy_o});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (pc_valid_o !== 1'b0 || busy_o !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL abort_no_redirect got %0d active cycles want 0", pulses);
        end
        $display("txn reset abort");
    endtask

    task automatic test_masked();
        int active = 0;
        status_i = 32'h0000_0403; cause_i = 32'h0000_0400; mem_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || excepttype_o !== 32'h0) active++;
        end
        status_i = 32'h0000_0401; mem_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (busy_o !== 1'b0) active++;
        end
        mem_exc_i = 5'b00100;
        repeat (2) begin
            @(negedge clk);
            if (busy_o !== 1'b0) active++;
        end
        idle_inputs();
        checks++;
        if (active != 0) begin
            errors++; $display("FAIL masked_no_event got %0d busy cycles want 0", active);
        end
        $display("txn masked interrupt / invalid slot ignored");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_code [8];
        logic [7:0]  exp_valid, exp_flush, got_valid, got_flush;
        int bad_code = 0;
        exp_code  = '{32'ha, 32'h0, 32'h0, 32'h0, 32'ha, 32'h0, 32'h0, 32'h0};
        exp_valid = 8'b0100_0100;
        exp_flush = 8'b0011_0011;
        mem_valid_i = 1'b1; mem_exc_i = 5'b00010; mem_pc_i = 32'h600;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (excepttype_o !== exp_code[k]) bad_code++;
            got_valid[k] = pc_valid_o;
            got_flush[k] = flush_o;
        end
        idle_inputs();
        checks++;
        if (bad_code != 0) begin
            errors++; $display("FAIL b2b_codes got %0d wrong cycles want 0", bad_code);
        end
        checks++;
        if (got_valid !== exp_valid) begin
            errors++; $display("FAIL b2b_pc_valid got %b want %b", got_valid, exp_valid);
        end
        checks++;
        if (got_flush !== exp_flush) begin
            errors++; $display("FAIL b2b_flush got %b want %b", got_flush, exp_flush);
        end
        repeat (4) @(negedge clk);
        $display("txn back-to-back invalid x2");
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_interrupt();
        test_eret();
        test_priority();
        test_reset_abort();
        test_masked();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
